// File: rtl/unioperand_pkg.sv
// unioperand_pkg: shared FSM/op encodings and default widths for the unioperand core and its data memory.
package unioperand_pkg;
  localparam int DEF_DATA_W = 8;
  localparam int DEF_ADDR_W = 5;
  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_e;
  typedef enum logic {OP_RD, OP_WR} op_e;
endpackage

// File: rtl/unioperand_mem_array.sv
// unioperand_mem_array: DEPTH x DATA_W single-port RAM, registered read, out-of-range writes dropped and reads return 0.
module unioperand_mem_array
  import unioperand_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DEPTH  = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we_i,
  input  logic              re_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [DATA_W-1:0] wdata_i,
  output logic [DATA_W-1:0] rdata_o
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [ADDR_W:0] DEPTH_W = (ADDR_W+1)'(DEPTH);
  logic [DATA_W-1:0] mem [DEPTH];
  logic in_range;
  logic [AW-1:0] idx;
  assign in_range = {1'b0, addr_i} < DEPTH_W;
  assign idx = addr_i[AW-1:0];
  always_ff @(posedge clk)
    if (we_i && in_range) mem[idx] <= wdata_i;
  always_ff @(posedge clk)
    if (rst) rdata_o <= '0;
    else if (re_i) rdata_o <= in_range ? mem[idx] : '0;
endmodule

// File: rtl/unioperand_mem_responder.sv
// unioperand_mem_responder: r/w strobe memory responder with WAIT_STATES latency; UNIOP_MEM_ERRCHK_EN enables err.
module unioperand_mem_responder
  import unioperand_pkg::*;
#(
  parameter int DATA_W      = DEF_DATA_W,
  parameter int ADDR_W      = DEF_ADDR_W,
  parameter int DEPTH       = 32,
  parameter int WAIT_STATES = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              r,
  input  logic              w,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata,
  output logic              ready,
  output logic              busy,
  output logic              err
);
  localparam logic [3:0] WS = 4'(WAIT_STATES);
  state_e state_q, state_d;
  op_e op_q, op_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [3:0] cnt_q, cnt_d;
  logic go;
  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: if (r || w) begin
        op_d    = w ? OP_WR : OP_RD;
        addr_d  = addr;
        wdata_d = wdata;
        cnt_d   = WS;
        state_d = (WAIT_STATES > 0) ? WAIT : RESP;
      end
      WAIT: begin
        cnt_d   = cnt_q - 4'd1;
        state_d = (cnt_q == 4'd1) ? RESP : WAIT;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk)
    if (rst) begin
      state_q <= IDLE;
      op_q    <= OP_RD;
      addr_q  <= '0;
      wdata_q <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      cnt_q   <= cnt_d;
    end
  // The array acts on the edge that enters RESP, using the operands being latched (or already held).
  assign go    = (state_d == RESP) && !rst;
  assign ready = state_q == RESP;
  assign busy  = state_q != IDLE;
  unioperand_mem_array #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH)) u_mem (
    .clk     (clk),
    .rst     (rst),
    .we_i    (go && op_d == OP_WR),
    .re_i    (go && op_d == OP_RD),
    .addr_i  (addr_d),
    .wdata_i (wdata_d),
    .rdata_o (rdata)
  );
`ifdef UNIOP_MEM_ERRCHK_EN
  localparam logic [ADDR_W:0] DEPTH_W = (ADDR_W+1)'(DEPTH);
  logic err_q;
  always_ff @(posedge clk)
    if (rst) err_q <= 1'b0;
    else if (state_q == IDLE && (r || w)) err_q <= (r && w) || !({1'b0, addr} < DEPTH_W);
  assign err = ready && err_q;
`else
  assign err = 1'b0;
`endif
endmodule
